// File: rtl/comp_div_pkg.sv
// Shared widths, FSM encoding and operand bundle for the sequential complex divider.
// Widths match the comp_mult_pipe datapath so downstream consumers can share them.
package comp_div_pkg;
  localparam int AW = 25;  // numerator / quotient
  localparam int BW = 18;  // denominator
  localparam int PW = 43;  // AW x BW product
  localparam int NW = 44;  // sum of two products
  localparam int DW = 36;  // |B|^2
  localparam int RW = 57;  // divider partial remainder

  localparam logic [AW-1:0] Q_MAX = 25'h0FF_FFFF;

  typedef enum logic [2:0] {IDLE, MULT, SUM, DIV, FIN} state_e;

  typedef struct packed {
    logic signed [AW-1:0] ar;
    logic signed [AW-1:0] ai;
    logic signed [BW-1:0] br;
    logic signed [BW-1:0] bi;
  } cdiv_req_t;

  function automatic logic [NW-1:0] mag(input logic signed [NW-1:0] v);
    return v[NW-1] ? -v : v;
  endfunction
endpackage

// File: rtl/comp_div_seq_udiv.sv
// Unsigned restoring divider, one quotient bit per step, MSB first.
// The quotient shifts into the dividend register as the dividend shifts out.
module seq_udiv #(
  parameter int NW   = 56,
  parameter int DW   = 36,
  parameter int RW   = 57,
  parameter int ITER = 56
) (
  input  logic          clk,
  input  logic          load,
  input  logic          step,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [NW-1:0] quotient,
  output logic [RW-1:0] remainder
);
  localparam int CNTW = $clog2(ITER + 1);

  logic [NW-1:0]   q;
  logic [RW-1:0]   r;
  logic [CNTW-1:0] n;
  logic [RW-1:0]   sh;
  logic [RW:0]     diff;

  assign sh   = {r[RW-2:0], q[NW-1]};
  assign diff = {1'b0, sh} - (RW+1)'(divisor);

  // Extra step pulses after ITER bits are produced leave the result intact.
  always_ff @(posedge clk) begin
    if (load) begin
      q <= dividend;
      r <= '0;
      n <= '0;
    end else if (step && n != CNTW'(ITER)) begin
      n <= n + 1'b1;
      if (!diff[RW]) begin
        r <= diff[RW-1:0];
        q <= {q[NW-2:0], 1'b1};
      end else begin
        r <= sh;
        q <= {q[NW-2:0], 1'b0};
      end
    end
  end

  assign quotient  = q;
  assign remainder = r;
endmodule

// File: rtl/comp_div_seq.sv
// Sequential complex divider Q = A*conj(B)/|B|^2, fixed point with FRAC fraction bits,
// truncated toward zero and saturated symmetrically to +/-(2^24-1).
module comp_div_seq
  import comp_div_pkg::*;
#(
  parameter int FRAC = 12
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic [AW-1:0] A_REAL,
  input  logic [AW-1:0] A_IMAGINARY,
  input  logic [BW-1:0] B_REAL,
  input  logic [BW-1:0] B_IMAGINARY,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] Q_REAL,
  output logic [AW-1:0] Q_IMAGINARY,
  output logic          DIV0,
  output logic          SAT
);
  localparam int ITER = NW + FRAC;
  localparam int CW   = $clog2(ITER + 1);

  state_e                  state;
  cdiv_req_t               op;
  logic signed [PW-1:0]    p_rr, p_ii, p_ir, p_ri;
  logic signed [DW-1:0]    sq_r, sq_i;
  logic [DW-1:0]           d, d_c;
  logic [1:0][NW-1:0]      n_c;
  logic [1:0][ITER-1:0]    dvd, quo;
  logic [1:0][RW-1:0]      rem;
  logic [1:0][AW-1:0]      q_res;
  logic [1:0]              neg, sat_l;
  logic [CW-1:0]           cnt;
  logic                    div0_r;
  logic                    ld, st;

  // Lane 0 is the real part, lane 1 the imaginary part.
  always_comb begin
    n_c[0] = NW'(p_rr) + NW'(p_ii);
    n_c[1] = NW'(p_ir) - NW'(p_ri);
    d_c    = sq_r + sq_i;
  end

  assign ld   = (state == SUM) && (d_c != '0);
  assign st   = (state == DIV);
  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK) begin
    case (state)
      IDLE: if (START) op <= {A_REAL, A_IMAGINARY, B_REAL, B_IMAGINARY};
      MULT: begin
        p_rr <= PW'($signed(op.ar)) * PW'($signed(op.br));
        p_ii <= PW'($signed(op.ai)) * PW'($signed(op.bi));
        p_ir <= PW'($signed(op.ai)) * PW'($signed(op.br));
        p_ri <= PW'($signed(op.ar)) * PW'($signed(op.bi));
        sq_r <= DW'($signed(op.br)) * DW'($signed(op.br));
        sq_i <= DW'($signed(op.bi)) * DW'($signed(op.bi));
      end
      SUM: begin
        d   <= d_c;
        neg <= {n_c[1][NW-1], n_c[0][NW-1]};
      end
      default: ;
    endcase
  end

  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [AW-1:0] qmag;

    assign dvd[l] = ITER'(mag(n_c[l])) << FRAC;

    seq_udiv #(
      .NW  (ITER),
      .DW  (DW),
      .RW  (RW),
      .ITER(ITER)
    ) u_div (
      .clk      (CLK),
      .load     (ld),
      .step     (st),
      .dividend (dvd[l]),
      .divisor  (d),
      .quotient (quo[l]),
      .remainder(rem[l])
    );

    // Clamp on magnitude so the negative limit is -(2^24-1), never -2^24.
    assign sat_l[l] = quo[l] > ITER'(Q_MAX);
    assign qmag     = sat_l[l] ? Q_MAX : quo[l][AW-1:0];
    assign q_res[l] = neg[l] ? -qmag : qmag;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      DONE        <= 1'b0;
      Q_REAL      <= '0;
      Q_IMAGINARY <= '0;
      DIV0        <= 1'b0;
      SAT         <= 1'b0;
      cnt         <= '0;
      div0_r      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: if (START) state <= MULT;
        MULT: state <= SUM;
        SUM: begin
          cnt    <= '0;
          div0_r <= (d_c == '0);
          state  <= (d_c == '0) ? FIN : DIV;
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) state <= FIN;
        end
        FIN: begin
          DONE  <= 1'b1;
          DIV0  <= div0_r;
          state <= IDLE;
          if (div0_r) begin
            Q_REAL      <= '0;
            Q_IMAGINARY <= '0;
            SAT         <= 1'b0;
          end else begin
            Q_REAL      <= q_res[0];
            Q_IMAGINARY <= q_res[1];
            SAT         <= |sat_l;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_comp_div_seq.sv
// Directed and randomized checks of comp_div_seq against an arithmetic model of A*conj(B)/|B|^2.
module tb_comp_div_seq;
  localparam int     FRAC = 12;
  localparam int     LAT  = 44 + FRAC + 3;
  localparam longint QMAX = 64'd16777215;

  logic        CLK = 1'b0, RST_N = 1'b0, START = 1'b0;
  logic [24:0] A_REAL = '0, A_IMAGINARY = '0;
  logic [17:0] B_REAL = '0, B_IMAGINARY = '0;
  logic        BUSY, DONE, DIV0, SAT;
  logic [24:0] Q_REAL, Q_IMAGINARY;

  int vectors = 0, miscompares = 0;

  comp_div_seq #(.FRAC(FRAC)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START),
    .A_REAL(A_REAL), .A_IMAGINARY(A_IMAGINARY),
    .B_REAL(B_REAL), .B_IMAGINARY(B_IMAGINARY),
    .BUSY(BUSY), .DONE(DONE),
    .Q_REAL(Q_REAL), .Q_IMAGINARY(Q_IMAGINARY),
    .DIV0(DIV0), .SAT(SAT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Quotient from the definition: multiply by conj(B), divide by |B|^2, truncate, clamp.
  function automatic void model(input longint ar, ai, br, bi,
                                output longint qr, qi, output logic dz, sat);
    longint d, q;
    longint n[2];
    qr = 0; qi = 0; dz = 1'b0; sat = 1'b0;
    d = br*br + bi*bi;
    if (d == 0) begin
      dz = 1'b1;
      return;
    end
    n[0] = ar*br + ai*bi;
    n[1] = ai*br - ar*bi;
    for (int i = 0; i < 2; i++) begin
      q = ((n[i] < 0 ? -n[i] : n[i]) * (64'sd1 << FRAC)) / d;
      if (q > QMAX) begin
        q = QMAX;
        sat = 1'b1;
      end
      if (n[i] < 0) q = -q;
      if (i == 0) qr = q; else qi = q;
    end
  endfunction

  function automatic longint r25();
    logic [24:0] v;
    v = 25'($urandom);
    return longint'($signed(v));
  endfunction

  function automatic longint r18();
    logic [17:0] v;
    v = 18'($urandom);
    return longint'($signed(v));
  endfunction

  // Returns in the DONE cycle, so the next call starts back-to-back.
  task automatic run_op(input string tag, input longint ar, ai, br, bi);
    longint eqr, eqi;
    logic   edz, est;
    int     lat;
    model(ar, ai, br, bi, eqr, eqi, edz, est);
    @(negedge CLK);
    A_REAL = 25'(ar); A_IMAGINARY = 25'(ai);
    B_REAL = 18'(br); B_IMAGINARY = 18'(bi);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    A_REAL = 25'($urandom); A_IMAGINARY = 25'($urandom);
    B_REAL = 18'($urandom); B_IMAGINARY = 18'($urandom);
    chk({tag, " busy"}, BUSY, 1);
    chk({tag, " done_low"}, DONE, 0);
    lat = 0;
    while (DONE !== 1'b1 && lat < 200) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, edz ? 3 : LAT);
    chk({tag, " q_real"}, $signed(Q_REAL), eqr);
    chk({tag, " q_imag"}, $signed(Q_IMAGINARY), eqi);
    chk({tag, " div0"}, DIV0, edz);
    chk({tag, " sat"}, SAT, est);
    chk({tag, " busy_done"}, BUSY, 0);
  endtask

  initial begin
    int           dn;
    int           pos[$];
    logic [63:0]  zero64;
    zero64 = '0;

    #12; #1;
    chk("rst busy", BUSY, 0);
    chk("rst done", DONE, 0);
    chk("rst q_real", Q_REAL, zero64);
    chk("rst q_imag", Q_IMAGINARY, zero64);
    chk("rst div0", DIV0, 0);
    chk("rst sat", SAT, 0);
    @(negedge CLK); RST_N = 1'b1;

    run_op("basic", 2, 2, 6, 2);
    run_op("trunc", 2020, 2000, 2020, 2020);
    run_op("div0", 5, 7, 0, 0);
    run_op("after_div0", -300, 77, -12, 5);
    run_op("sat_pos", 16777215, 0, 1, 0);
    run_op("sat_neg", -16777215, 0, 1, 0);

    // Asynchronous reset in the middle of the divide.
    @(negedge CLK);
    A_REAL = 25'd1000; A_IMAGINARY = 25'd3; B_REAL = 18'd7; B_IMAGINARY = 18'd2;
    START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    repeat (22) @(posedge CLK);
    #1; chk("mid busy", BUSY, 1);
    #2; RST_N = 1'b0;
    #1;
    chk("arst busy", BUSY, 0);
    chk("arst done", DONE, 0);
    chk("arst q_real", Q_REAL, zero64);
    chk("arst q_imag", Q_IMAGINARY, zero64);
    chk("arst div0", DIV0, 0);
    chk("arst sat", SAT, 0);
    @(negedge CLK); RST_N = 1'b1;
    dn = 0;
    repeat (80) begin
      @(posedge CLK); #1;
      if (DONE === 1'b1) dn++;
    end
    chk("arst no_done", dn, 0);
    run_op("post_rst", 10, 14, 10, 10);

    // START held high: accepted again only in each DONE cycle.
    @(negedge CLK);
    A_REAL = 25'd2; A_IMAGINARY = 25'd2; B_REAL = 18'd6; B_IMAGINARY = 18'd2;
    START = 1'b1;
    for (int i = 0; i < 190; i++) begin
      @(posedge CLK); #1;
      if (DONE === 1'b1) pos.push_back(i);
    end
    chk("hold count", pos.size(), 3);
    chk("hold done0", pos.size() > 0 ? pos[0] : -1, LAT);
    chk("hold done1", pos.size() > 1 ? pos[1] : -1, 2*LAT + 1);
    chk("hold done2", pos.size() > 2 ? pos[2] : -1, 3*LAT + 2);
    chk("hold q_real", $signed(Q_REAL), 1638);
    @(negedge CLK); START = 1'b0;
    dn = 0;
    while (BUSY !== 1'b0 && dn < 200) begin
      @(posedge CLK); #1;
      dn++;
    end
    chk("hold drain", BUSY, 0);

    for (int i = 0; i < 24; i++) begin
      longint ar, ai, br, bi;
      ar = r25(); ai = r25();
      case (i % 4)
        0: begin br = r18(); bi = r18(); end
        1: begin br = longint'($urandom_range(0, 40)) - 20; bi = longint'($urandom_range(0, 40)) - 20; end
        2: begin br = r18(); bi = 0; ar = ar / 64; ai = ai / 4096; end
        default: begin br = ($urandom_range(0, 2) == 0) ? 0 : r18(); bi = 0; end
      endcase
      run_op($sformatf("rand%0d", i), ar, ai, br, bi);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/comp_div_seq.md
# comp_div_seq

Sequential complex divider that performs the inverse of the pipelined complex multiplier. It computes Q = A / B for a 25-bit signed complex A and an 18-bit signed complex B, using Q = A·conj(B) / |B|². The result is fixed-point with FRAC fractional bits, truncated toward zero and saturated to 25 bits. It sits on the DSP48E datapath next to comp_mult_pipe and normalises or equalises complex samples where an iterative, low-area divide is acceptable.

## Interface
- FRAC, 12: number of fractional bits in Q_REAL/Q_IMAGINARY (range 0..20).
- CLK  in  1  rising-edge clock.
- RST_N  in  1  reset, asynchronous, active-low.
- START  in  1  request; sampled only in IDLE.
- A_REAL, A_IMAGINARY  in  25 each  numerator, signed two's complement.
- B_REAL, B_IMAGINARY  in  18 each  denominator, signed two's complement.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle pulse; outputs are valid from this cycle on.
- Q_REAL, Q_IMAGINARY  out  25 each  signed quotient, scaled by 2^FRAC, held until the next DONE.
- DIV0  out  1  last operation had B = 0.
- SAT  out  1  last operation saturated the real part, the imaginary part, or both.
- Clock is CLK. Reset is RST_N: one clock, asynchronous assert, active-low.

## Operation
- FSM states: IDLE, MULT, SUM, DIV, FIN.
- IDLE with START=1: register the A and B operands, go to MULT. START is ignored in every other state.
- MULT: register four signed 25×18 products (43 bits each): ar·br, ai·bi, ai·br, ar·bi. Also register br², bi² (36 bits each).
- SUM: compute the following into registers.
  - NR = ar·br + ai·bi (44-bit signed).
  - NI = ai·br − ar·bi (44-bit signed).
  - D = br² + bi² (36-bit unsigned; max 2^35).
- SUM, sign and magnitude handling: latch the sign of NR and NI, then take their magnitudes. If D = 0, go directly to FIN with DIV0=1.
- DIV: two restoring dividers run in parallel on |NR|·2^FRAC and |NI|·2^FRAC, sharing divisor D.
  - ITER = 44 + FRAC iterations, one quotient bit per cycle, MSB first.
  - 57-bit partial remainder.
- FIN, normal case:
  - Magnitude quotient > 2^24−1: clamp to 2^24−1 and set SAT.
  - Otherwise apply the latched sign. The result is truncated toward zero.
  - Update Q_*, DIV0 and SAT, pulse DONE, return to IDLE.
- FIN, DIV0 case: Q_REAL = Q_IMAGINARY = 0, SAT=0.
- Negative saturation: −(2^24−1). The value −2^24 is never produced.

## Timing
- Reset values: BUSY=0, DONE=0, Q_REAL=0, Q_IMAGINARY=0, DIV0=0, SAT=0, state IDLE. The multiply and divide registers are don't-care.
- START sampled high at edge k:
  - BUSY=1 from k.
  - MULT at k+1, SUM at k+2, DIV at k+3 .. k+2+ITER.
  - DONE high for the cycle after edge k+3+ITER.
  - Latency L = ITER+3 = 59 cycles at FRAC=12.
- Divide by zero: DONE after edge k+3, so latency is 3.
- BUSY falls in the same cycle DONE rises. START may be high in the DONE cycle and is accepted, giving back-to-back operations with 1-cycle spacing.
- Operands may change after edge k; they are captured at k.
- RST_N low in any state: all outputs take reset values immediately and the FSM returns to IDLE. The next START after release starts a clean operation.

## Structure
- Package comp_div_pkg holds the following. Consumers of comp_mult_pipe outputs also use these widths.
  - Width constants: AW=25, BW=18, PW=43, NW=44, DW=36.
  - The state enum {IDLE, MULT, SUM, DIV, FIN}.
  - Q_MAX = 2^24−1.
- Sub-module seq_udiv: unsigned restoring divider, one bit per cycle.
  - Parameters: dividend width, divisor width, iteration count.
  - Ports: load, step, quotient, remainder.
  - Instantiated twice, real and imaginary, sharing divisor D.
- Top level holds the FSM, products, sign and magnitude handling, and saturation.

## Test plan
- A=2+j2, B=6+j2, FRAC=12 → Q_REAL=1638, Q_IMAGINARY=819, DIV0=0, SAT=0; DONE exactly 59 cycles after START.
- A=2020+j2000, B=2020+j2020 → Q_REAL=4075, Q_IMAGINARY=−20. This checks truncation toward zero on a negative part.
- A=5+j7, B=0+j0 → DIV0=1, Q=0+j0, DONE 3 cycles after START. A following valid operation clears DIV0.
- A=16777215+j0, B=1+j0 → Q_REAL=16777215, SAT=1, Q_IMAGINARY=0. With A=−16777215 the result is Q_REAL=−16777215, SAT=1.
- RST_N low at cycle 20 of DIV → outputs go to reset values asynchronously. After release, START with A=10+j14, B=10+j10 → Q_REAL=4915, Q_IMAGINARY=819.
- START held high through a whole operation → a second operation is accepted in the DONE cycle. Each DONE is exactly one cycle wide, with no START accepted while BUSY.
